// File: rtl/fft_input_loader.sv
// Feeds the FFT stage register array from a valid/ready sample stream.
// Samples are written in natural or bit-reversed order; the full frame is held until acknowledged.
module fft_input_loader #(
  parameter int N      = 16,
  parameter int MSB    = 16,
  parameter int BITREV = 1,
  localparam int AW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [MSB-1:0]  s_data,
  output logic            s_ready,
  input  logic            flush,
  input  logic            frame_ack,
  output logic            we,
  output logic [AW-1:0]   addr,
  output logic [MSB-1:0]  data,
  output logic            frame_ready,
  output logic [AW:0]     sample_cnt
);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(N - 1);

  state_t state;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = v[AW-1-i];
    end
    return r;
  endfunction

  // Ready only depends on registered state, so upstream sees no combinational path from s_valid.
  always_comb begin
    s_ready = (state == LOAD) && !rst;
  end

  // Frame FSM and registered write port; precedence is rst > flush > frame_ack > accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      sample_cnt  <= '0;
      we          <= 1'b0;
      addr        <= '0;
      data        <= '0;
      frame_ready <= 1'b0;
    end else if (flush) begin
      state       <= LOAD;
      sample_cnt  <= '0;
      we          <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        LOAD: begin
          if (s_valid) begin
            we         <= 1'b1;
            data       <= s_data;
            addr       <= (BITREV != 0) ? bitrev(sample_cnt[AW-1:0]) : sample_cnt[AW-1:0];
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_IDX) begin
              state       <= FULL;
              frame_ready <= 1'b1;
            end else begin
              state       <= LOAD;
            end
          end else begin
            state <= LOAD;
          end
        end
        FULL: begin
          // Acknowledge only reopens the frame; no sample is taken on the ack edge.
          if (frame_ack) begin
            state       <= LOAD;
            sample_cnt  <= '0;
            frame_ready <= 1'b0;
          end else begin
            state <= FULL;
          end
        end
        default: begin
          state       <= LOAD;
          sample_cnt  <= '0;
          frame_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: a bit-reversed and a natural-order instance share
// one stimulus stream; a negedge-written array model captures what each one stores.
module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst, s_valid, flush, frame_ack;
  logic [15:0] s_data;

  logic        b_ready, b_we, b_fr;
  logic [3:0]  b_addr;
  logic [15:0] b_data;
  logic [4:0]  b_cnt;
  logic        n_ready, n_we, n_fr;
  logic [3:0]  n_addr;
  logic [15:0] n_data;
  logic [4:0]  n_cnt;

  logic [15:0] mem_b [16];
  logic [15:0] mem_n [16];

  int nchk = 0;
  int nerr = 0;
  int brtab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft_input_loader #(.N(16), .MSB(16), .BITREV(1)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(b_ready),
    .flush(flush), .frame_ack(frame_ack), .we(b_we), .addr(b_addr), .data(b_data),
    .frame_ready(b_fr), .sample_cnt(b_cnt)
  );

  fft_input_loader #(.N(16), .MSB(16), .BITREV(0)) dut_n (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(n_ready),
    .flush(flush), .frame_ack(frame_ack), .we(n_we), .addr(n_addr), .data(n_data),
    .frame_ready(n_fr), .sample_cnt(n_cnt)
  );

  // Register array model: writes land on the negedge inside the write cycle.
  always @(negedge clk) begin
    if (b_we) mem_b[b_addr] <= b_data;
    if (n_we) mem_n[n_addr] <= n_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    logic [15:0] last_data;
    logic [39:0] pat;
    pat = 40'b1011_0010_1101_1001_0110_1011_0011_0101_1101_0110;

    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000; flush = 1'b0; frame_ack = 1'b0;
    tick();
    tick();
    chk("rst_s_ready", 32'(b_ready), 32'd0);
    chk("rst_we", 32'(b_we), 32'd0);
    chk("rst_addr", 32'(b_addr), 32'd0);
    chk("rst_data", 32'(b_data), 32'd0);
    chk("rst_frame_ready", 32'(b_fr), 32'd0);
    chk("rst_cnt", 32'(b_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", 32'(b_ready), 32'd1);

    // Full frame of samples 0..15, back to back.
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1; s_data = 16'(k);
      tick();
      chk("f1_we", 32'(b_we), 32'd1);
      chk("f1_addr_bitrev", 32'(b_addr), 32'(brtab[k]));
      chk("f1_addr_natural", 32'(n_addr), 32'(k));
      chk("f1_data", 32'(b_data), 32'(k));
      chk("f1_cnt", 32'(b_cnt), 32'(k + 1));
      chk("f1_frame_ready", 32'(b_fr), (k == 15) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #1;
    chk("f1_word8", 32'(mem_b[8]), 32'd1);
    chk("f1_word15", 32'(mem_b[15]), 32'd15);
    for (int i = 0; i < 16; i++) begin
      chk("f1_bitrev_word", 32'(mem_b[brtab[i]]), 32'(i));
      chk("f1_natural_word", 32'(mem_n[i]), 32'(i));
    end

    // FULL holds off upstream for 5 cycles, then the ack reopens the frame.
    s_valid = 1'b1; s_data = 16'h0055;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_s_ready", 32'(b_ready), 32'd0);
      chk("hold_we", 32'(b_we), 32'd0);
      chk("hold_cnt", 32'(b_cnt), 32'd16);
      chk("hold_frame_ready", 32'(b_fr), 32'd1);
    end
    frame_ack = 1'b1;
    tick();
    chk("ack_frame_ready", 32'(b_fr), 32'd0);
    chk("ack_s_ready", 32'(b_ready), 32'd1);
    chk("ack_cnt", 32'(b_cnt), 32'd0);
    chk("ack_no_accept", 32'(b_we), 32'd0);
    frame_ack = 1'b0; s_data = 16'h00A0;
    tick();
    chk("after_ack_we", 32'(b_we), 32'd1);
    chk("after_ack_addr", 32'(b_addr), 32'd0);
    chk("after_ack_data", 32'(b_data), 32'h00A0);
    chk("after_ack_cnt", 32'(b_cnt), 32'd1);

    // Gappy stream completes the frame; we must track s_valid exactly.
    idx = 1;
    last_data = 16'h00A0;
    for (int i = 0; i < 40 && idx < 16; i++) begin
      s_valid = pat[39-i];
      s_data = s_valid ? 16'(16'h0100 + idx) : 16'hDEAD;
      tick();
      if (s_valid) begin
        chk("gap_we", 32'(b_we), 32'd1);
        chk("gap_addr", 32'(b_addr), 32'(brtab[idx]));
        chk("gap_data", 32'(b_data), 32'(16'h0100 + idx));
        last_data = 16'(16'h0100 + idx);
        idx++;
      end else begin
        chk("gap_idle_we", 32'(b_we), 32'd0);
        chk("gap_data_hold", 32'(b_data), 32'(last_data));
      end
      chk("gap_cnt", 32'(b_cnt), 32'(idx));
      chk("gap_frame_ready", 32'(b_fr), (idx == 16) ? 32'd1 : 32'd0);
    end
    chk("gap_frame_done", 32'(idx), 32'd16);
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("gap_word0", 32'(mem_b[0]), 32'h00A0);
    for (int i = 1; i < 16; i++) begin
      chk("gap_word", 32'(mem_b[brtab[i]]), 32'(16'h0100 + i));
    end
    frame_ack = 1'b1;
    tick();

    // frame_ack stays high in LOAD and must not disturb accepts; then flush after 7.
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1; s_data = 16'(16'h0200 + k);
      tick();
      chk("pre_flush_cnt", 32'(b_cnt), 32'(k + 1));
      chk("pre_flush_addr", 32'(b_addr), 32'(brtab[k]));
    end
    frame_ack = 1'b0;
    flush = 1'b1; s_data = 16'hBEEF;
    #1;
    chk("flush_s_ready", 32'(b_ready), 32'd1);
    tick();
    chk("flush_we", 32'(b_we), 32'd0);
    chk("flush_cnt", 32'(b_cnt), 32'd0);
    chk("flush_data_hold", 32'(b_data), 32'h0206);
    @(negedge clk);
    #1;
    chk("flush_word14_kept", 32'(mem_b[14]), 32'h0107);
    flush = 1'b0; s_data = 16'h0300;
    tick();
    chk("post_flush_addr", 32'(b_addr), 32'd0);
    chk("post_flush_data", 32'(b_data), 32'h0300);
    chk("post_flush_cnt", 32'(b_cnt), 32'd1);

    // Fill to FULL, then rst together with frame_ack.
    for (int k = 1; k < 16; k++) begin
      s_data = 16'(16'h0300 + k);
      tick();
    end
    chk("full_again", 32'(b_fr), 32'd1);
    s_valid = 1'b0;
    rst = 1'b1; frame_ack = 1'b1;
    #1;
    chk("rst_full_s_ready_comb", 32'(b_ready), 32'd0);
    tick();
    chk("rst_full_frame_ready", 32'(b_fr), 32'd0);
    chk("rst_full_cnt", 32'(b_cnt), 32'd0);
    chk("rst_full_s_ready", 32'(b_ready), 32'd0);
    chk("rst_full_addr", 32'(b_addr), 32'd0);
    rst = 1'b0; frame_ack = 1'b0;
    #1;
    chk("rst_full_release_ready", 32'(b_ready), 32'd1);
    tick();
    chk("idle_we", 32'(b_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
